// File: rtl/axi_shim_arbiter_pkg.sv
// Shared types and ID tagging helpers for the axi_shim request arbiter.
// A shim ID carries the requester index above the requester's local ID bits.
package axi_shim_arb_pkg;

    typedef logic [2:0] port_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [15:0] tag_id(
        input port_idx_t   idx,
        input logic [15:0] loc,
        input int unsigned lw
    );
        return (16'(idx) << lw) | loc;
    endfunction

    function automatic port_idx_t port_of(
        input logic [15:0] id,
        input int unsigned lw
    );
        return port_idx_t'(id >> lw);
    endfunction

endpackage

// File: rtl/axi_shim_arbiter_if.sv
// Requester-side and shim-side signal bundle of the axi_shim arbiter.
// slave is the arbiter's view; master is the requester/shim environment.
interface axi_shim_arbiter_if #(
    parameter int NumPorts     = 3,
    parameter int AxiIdWidth   = 4,
    parameter int AxiNumWords  = 4,
    parameter int AxiUserWidth = 64
);
    localparam int PortIdxWidth = $clog2(NumPorts);
    localparam int LocalIdWidth = AxiIdWidth - PortIdxWidth;
    localparam int BlenWidth    = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1;

    logic [NumPorts-1:0]     port_rd_req_i;
    logic [NumPorts-1:0]     port_rd_gnt_o;
    logic [63:0]             port_rd_addr_i [NumPorts];
    logic [BlenWidth-1:0]    port_rd_blen_i [NumPorts];
    logic [1:0]              port_rd_size_i [NumPorts];
    logic [NumPorts-1:0]     port_rd_lock_i;
    logic [LocalIdWidth-1:0] port_rd_id_i   [NumPorts];
    logic [NumPorts-1:0]     port_rd_valid_o;
    logic [NumPorts-1:0]     port_rd_last_o;
    logic [NumPorts-1:0]     port_rd_exokay_o;
    logic [NumPorts-1:0]     port_rd_rdy_i;
    logic [63:0]             port_rd_data_o;
    logic [AxiUserWidth-1:0] port_rd_user_o;
    logic [LocalIdWidth-1:0] port_rd_id_o;

    logic [NumPorts-1:0]     port_wr_req_i;
    logic [NumPorts-1:0]     port_wr_gnt_o;
    logic [63:0]             port_wr_addr_i [NumPorts];
    logic [63:0]             port_wr_data_i [NumPorts];
    logic [AxiUserWidth-1:0] port_wr_user_i [NumPorts];
    logic [7:0]              port_wr_be_i   [NumPorts];
    logic [BlenWidth-1:0]    port_wr_blen_i [NumPorts];
    logic [1:0]              port_wr_size_i [NumPorts];
    logic [NumPorts-1:0]     port_wr_lock_i;
    logic [5:0]              port_wr_atop_i [NumPorts];
    logic [LocalIdWidth-1:0] port_wr_id_i   [NumPorts];
    logic [NumPorts-1:0]     port_wr_valid_o;
    logic [NumPorts-1:0]     port_wr_exokay_o;
    logic [NumPorts-1:0]     port_wr_rdy_i;
    logic [LocalIdWidth-1:0] port_wr_id_o;

    logic                    shim_rd_req_o;
    logic                    shim_rd_gnt_i;
    logic [63:0]             shim_rd_addr_o;
    logic [BlenWidth-1:0]    shim_rd_blen_o;
    logic [1:0]              shim_rd_size_o;
    logic                    shim_rd_lock_o;
    logic [AxiIdWidth-1:0]   shim_rd_id_o;
    logic                    shim_rd_valid_i;
    logic                    shim_rd_last_i;
    logic                    shim_rd_exokay_i;
    logic [63:0]             shim_rd_data_i;
    logic [AxiUserWidth-1:0] shim_rd_user_i;
    logic [AxiIdWidth-1:0]   shim_rd_id_i;
    logic                    shim_rd_rdy_o;

    logic                    shim_wr_req_o;
    logic                    shim_wr_gnt_i;
    logic [63:0]             shim_wr_addr_o;
    logic [63:0]             shim_wr_data_o;
    logic [AxiUserWidth-1:0] shim_wr_user_o;
    logic [7:0]              shim_wr_be_o;
    logic [BlenWidth-1:0]    shim_wr_blen_o;
    logic [1:0]              shim_wr_size_o;
    logic                    shim_wr_lock_o;
    logic [5:0]              shim_wr_atop_o;
    logic [AxiIdWidth-1:0]   shim_wr_id_o;
    logic                    shim_wr_valid_i;
    logic                    shim_wr_exokay_i;
    logic [AxiIdWidth-1:0]   shim_wr_id_i;
    logic                    shim_wr_rdy_o;

    modport slave (
        input  port_rd_req_i, port_rd_addr_i, port_rd_blen_i,
        input  port_rd_size_i, port_rd_lock_i, port_rd_id_i, port_rd_rdy_i,
        output port_rd_gnt_o, port_rd_valid_o, port_rd_last_o,
        output port_rd_exokay_o, port_rd_data_o, port_rd_user_o, port_rd_id_o,
        input  port_wr_req_i, port_wr_addr_i, port_wr_data_i, port_wr_user_i,
        input  port_wr_be_i, port_wr_blen_i, port_wr_size_i, port_wr_lock_i,
        input  port_wr_atop_i, port_wr_id_i, port_wr_rdy_i,
        output port_wr_gnt_o, port_wr_valid_o, port_wr_exokay_o, port_wr_id_o,
        output shim_rd_req_o, shim_rd_addr_o, shim_rd_blen_o, shim_rd_size_o,
        output shim_rd_lock_o, shim_rd_id_o, shim_rd_rdy_o,
        input  shim_rd_gnt_i, shim_rd_valid_i, shim_rd_last_i,
        input  shim_rd_exokay_i, shim_rd_data_i, shim_rd_user_i, shim_rd_id_i,
        output shim_wr_req_o, shim_wr_addr_o, shim_wr_data_o, shim_wr_user_o,
        output shim_wr_be_o, shim_wr_blen_o, shim_wr_size_o, shim_wr_lock_o,
        output shim_wr_atop_o, shim_wr_id_o, shim_wr_rdy_o,
        input  shim_wr_gnt_i, shim_wr_valid_i, shim_wr_exokay_i, shim_wr_id_i
    );

    modport master (
        output port_rd_req_i, port_rd_addr_i, port_rd_blen_i,
        output port_rd_size_i, port_rd_lock_i, port_rd_id_i, port_rd_rdy_i,
        input  port_rd_gnt_o, port_rd_valid_o, port_rd_last_o,
        input  port_rd_exokay_o, port_rd_data_o, port_rd_user_o, port_rd_id_o,
        output port_wr_req_i, port_wr_addr_i, port_wr_data_i, port_wr_user_i,
        output port_wr_be_i, port_wr_blen_i, port_wr_size_i, port_wr_lock_i,
        output port_wr_atop_i, port_wr_id_i, port_wr_rdy_i,
        input  port_wr_gnt_o, port_wr_valid_o, port_wr_exokay_o, port_wr_id_o,
        input  shim_rd_req_o, shim_rd_addr_o, shim_rd_blen_o, shim_rd_size_o,
        input  shim_rd_lock_o, shim_rd_id_o, shim_rd_rdy_o,
        output shim_rd_gnt_i, shim_rd_valid_i, shim_rd_last_i,
        output shim_rd_exokay_i, shim_rd_data_i, shim_rd_user_i, shim_rd_id_i,
        input  shim_wr_req_o, shim_wr_addr_o, shim_wr_data_o, shim_wr_user_o,
        input  shim_wr_be_o, shim_wr_blen_o, shim_wr_size_o, shim_wr_lock_o,
        input  shim_wr_atop_o, shim_wr_id_o, shim_wr_rdy_o,
        output shim_wr_gnt_i, shim_wr_valid_i, shim_wr_exokay_i, shim_wr_id_i
    );

endinterface

// File: rtl/axi_shim_arbiter_rr_arb.sv
// Round-robin priority picker: first requester at or after ptr wins.
// Produces a one-hot select, a valid flag and the binary index.
module rr_arb #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // walk from the farthest offset down so the nearest request wins
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                sel    = '0;
                sel[j] = 1'b1;
                valid  = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/axi_shim_arbiter.sv
// Round-robin arbiter sharing one axi_shim among NumPorts requesters.
// Optional AXI_SHIM_ARB_STATS_EN adds per-channel stall cycle counters.
module axi_shim_arbiter
    import axi_shim_arb_pkg::*;
#(
    parameter int NumPorts       = 3,
    parameter int AxiIdWidth     = 4,
    parameter int AxiNumWords    = 4,
    parameter int AxiUserWidth   = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    axi_shim_arbiter_if.slave bus,
    output logic route_err_o
`ifdef AXI_SHIM_ARB_STATS_EN
    ,
    output logic [31:0] stat_rd_stall_o,
    output logic [31:0] stat_wr_stall_o
`endif
);

    localparam int PW = $clog2(NumPorts);
    localparam int LW = AxiIdWidth - PW;
    localparam int CW = $clog2(MaxOutstanding + 1);

    localparam logic [0:0] S_IDLE   = 1'(IDLE);
    localparam logic [0:0] S_LOCKED = 1'(LOCKED);

    typedef logic [PW-1:0] pidx_t;

    function automatic pidx_t nxt(input pidx_t p);
        return (int'(p) == NumPorts - 1) ? '0 : pidx_t'(p + 1'b1);
    endfunction

    function automatic logic [CW-1:0] cnt_upd(
        input logic [CW-1:0] c,
        input logic          inc,
        input logic          dec
    );
        if (inc && !dec && c != '1) return c + 1'b1;
        if (dec && !inc && c != '0) return c - 1'b1;
        return c;
    endfunction

    logic [CW-1:0]       rd_cnt [NumPorts];
    logic [CW-1:0]       wr_cnt [NumPorts];
    logic [NumPorts-1:0] rd_elig, wr_elig;
    logic [NumPorts-1:0] rd_oh, wr_oh;
    logic                rd_pvld, wr_pvld;
    pidx_t               rd_pick, wr_pick;
    pidx_t               rd_cur, wr_cur;
    pidx_t               rd_rr_q, wr_rr_q;
    pidx_t               rd_sel_q, wr_sel_q;
    logic [0:0]          rd_state_q, wr_state_q;
    logic                rd_act, wr_act;
    logic                rd_fire, wr_fire;
    port_idx_t           rd_port, wr_port;
    logic                rd_ok, wr_ok;
    logic                rd_hs, wr_hs;
    logic                route_err_q;

    always_comb begin
        rd_elig = '0;
        wr_elig = '0;
        for (int p = 0; p < NumPorts; p++) begin
            rd_elig[p] = bus.port_rd_req_i[p] && (rd_cnt[p] < CW'(MaxOutstanding));
            wr_elig[p] = bus.port_wr_req_i[p] && (wr_cnt[p] < CW'(MaxOutstanding));
        end
    end

    rr_arb #(.N(NumPorts), .IW(PW)) u_rd_arb (
        .req   (rd_elig),
        .ptr   (rd_rr_q),
        .sel   (rd_oh),
        .valid (rd_pvld),
        .idx   (rd_pick)
    );

    rr_arb #(.N(NumPorts), .IW(PW)) u_wr_arb (
        .req   (wr_elig),
        .ptr   (wr_rr_q),
        .sel   (wr_oh),
        .valid (wr_pvld),
        .idx   (wr_pick)
    );

    // a locked channel holds its selection whatever the requesters do
    assign rd_cur  = (rd_state_q == S_LOCKED) ? rd_sel_q : rd_pick;
    assign wr_cur  = (wr_state_q == S_LOCKED) ? wr_sel_q : wr_pick;
    assign rd_act  = !rst_i && ((rd_state_q == S_LOCKED) || rd_pvld);
    assign wr_act  = !rst_i && ((wr_state_q == S_LOCKED) || wr_pvld);
    assign rd_fire = rd_act && bus.shim_rd_gnt_i;
    assign wr_fire = wr_act && bus.shim_wr_gnt_i;

    assign bus.port_rd_gnt_o = {NumPorts{rd_fire}} & ((rd_state_q == S_LOCKED)
                             ? (NumPorts'(1) << rd_sel_q) : rd_oh);
    assign bus.port_wr_gnt_o = {NumPorts{wr_fire}} & ((wr_state_q == S_LOCKED)
                             ? (NumPorts'(1) << wr_sel_q) : wr_oh);

    assign bus.shim_rd_req_o  = rd_act;
    assign bus.shim_rd_addr_o = bus.port_rd_addr_i[rd_cur];
    assign bus.shim_rd_blen_o = bus.port_rd_blen_i[rd_cur];
    assign bus.shim_rd_size_o = bus.port_rd_size_i[rd_cur];
    assign bus.shim_rd_lock_o = bus.port_rd_lock_i[rd_cur];
    assign bus.shim_rd_id_o   = AxiIdWidth'(tag_id(port_idx_t'(rd_cur),
                                16'(bus.port_rd_id_i[rd_cur]), LW));

    assign bus.shim_wr_req_o  = wr_act;
    assign bus.shim_wr_addr_o = bus.port_wr_addr_i[wr_cur];
    assign bus.shim_wr_data_o = bus.port_wr_data_i[wr_cur];
    assign bus.shim_wr_user_o = bus.port_wr_user_i[wr_cur];
    assign bus.shim_wr_be_o   = bus.port_wr_be_i[wr_cur];
    assign bus.shim_wr_blen_o = bus.port_wr_blen_i[wr_cur];
    assign bus.shim_wr_size_o = bus.port_wr_size_i[wr_cur];
    assign bus.shim_wr_lock_o = bus.port_wr_lock_i[wr_cur];
    assign bus.shim_wr_atop_o = bus.port_wr_atop_i[wr_cur];
    assign bus.shim_wr_id_o   = AxiIdWidth'(tag_id(port_idx_t'(wr_cur),
                                16'(bus.port_wr_id_i[wr_cur]), LW));

    assign rd_port = port_of(16'(bus.shim_rd_id_i), LW);
    assign wr_port = port_of(16'(bus.shim_wr_id_i), LW);
    assign rd_ok   = int'(rd_port) < NumPorts;
    assign wr_ok   = int'(wr_port) < NumPorts;

    // unroutable responses are swallowed so the shim never stalls on them
    always_comb begin
        bus.shim_rd_rdy_o    = !rd_ok;
        bus.shim_wr_rdy_o    = !wr_ok;
        bus.port_rd_valid_o  = '0;
        bus.port_rd_last_o   = '0;
        bus.port_rd_exokay_o = '0;
        bus.port_wr_valid_o  = '0;
        bus.port_wr_exokay_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (rd_port == port_idx_t'(p)) begin
                bus.shim_rd_rdy_o       = bus.port_rd_rdy_i[p];
                bus.port_rd_valid_o[p]  = !rst_i && bus.shim_rd_valid_i;
                bus.port_rd_last_o[p]   = !rst_i && bus.shim_rd_last_i;
                bus.port_rd_exokay_o[p] = !rst_i && bus.shim_rd_exokay_i;
            end
            if (wr_port == port_idx_t'(p)) begin
                bus.shim_wr_rdy_o       = bus.port_wr_rdy_i[p];
                bus.port_wr_valid_o[p]  = !rst_i && bus.shim_wr_valid_i;
                bus.port_wr_exokay_o[p] = !rst_i && bus.shim_wr_exokay_i;
            end
        end
    end

    assign bus.port_rd_data_o = bus.shim_rd_data_i;
    assign bus.port_rd_user_o = bus.shim_rd_user_i;
    assign bus.port_rd_id_o   = bus.shim_rd_id_i[LW-1:0];
    assign bus.port_wr_id_o   = bus.shim_wr_id_i[LW-1:0];

    assign rd_hs = bus.shim_rd_valid_i && bus.shim_rd_rdy_o && bus.shim_rd_last_i;
    assign wr_hs = bus.shim_wr_valid_i && bus.shim_wr_rdy_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q  <= S_IDLE;
            wr_state_q  <= S_IDLE;
            rd_rr_q     <= '0;
            wr_rr_q     <= '0;
            rd_sel_q    <= '0;
            wr_sel_q    <= '0;
            route_err_q <= 1'b0;
            for (int p = 0; p < NumPorts; p++) begin
                rd_cnt[p] <= '0;
                wr_cnt[p] <= '0;
            end
        end else begin
            if (rd_fire) begin
                rd_state_q <= S_IDLE;
                rd_rr_q    <= nxt(rd_cur);
            end else if (rd_act) begin
                rd_state_q <= S_LOCKED;
                rd_sel_q   <= rd_cur;
            end
            if (wr_fire) begin
                wr_state_q <= S_IDLE;
                wr_rr_q    <= nxt(wr_cur);
            end else if (wr_act) begin
                wr_state_q <= S_LOCKED;
                wr_sel_q   <= wr_cur;
            end
            for (int p = 0; p < NumPorts; p++) begin
                rd_cnt[p] <= cnt_upd(rd_cnt[p], bus.port_rd_gnt_o[p],
                                     rd_hs && rd_port == port_idx_t'(p));
                wr_cnt[p] <= cnt_upd(wr_cnt[p], bus.port_wr_gnt_o[p],
                                     wr_hs && wr_port == port_idx_t'(p));
            end
            if ((bus.shim_rd_valid_i && !rd_ok) || (bus.shim_wr_valid_i && !wr_ok))
                route_err_q <= 1'b1;
        end
    end

    assign route_err_o = route_err_q;

`ifdef AXI_SHIM_ARB_STATS_EN
    logic [31:0] rd_stall_q, wr_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_stall_q <= '0;
            wr_stall_q <= '0;
        end else begin
            if (|bus.port_rd_req_i && !rd_fire) rd_stall_q <= rd_stall_q + 1'b1;
            if (|bus.port_wr_req_i && !wr_fire) wr_stall_q <= wr_stall_q + 1'b1;
        end
    end

    assign stat_rd_stall_o = rd_stall_q;
    assign stat_wr_stall_o = wr_stall_q;
`endif

endmodule

// File: doc/axi_shim_arbiter.md
# axi_shim_arbiter

Round-robin arbiter that shares one `axi_shim` read/write request interface between `NumPorts` requesters (e.g. icache, dcache, bypass/AMO path). It tags each transaction's AXI ID with the requester index and routes R and B responses back by that tag. It enforces AXI valid-stability by locking a selection until the shim grants it. It caps in-flight transactions per requester. The block sits directly between the cache-side requesters and a single `axi_shim` instance.

## Interface
- `NumPorts`, 3: number of requesters, 2..8
- `AxiIdWidth`, 4: shim ID width; `PortIdxWidth = $clog2(NumPorts)` is derived; `LocalIdWidth = AxiIdWidth - PortIdxWidth` must be ≥1
- `AxiNumWords`, 4: maximum burst length; sets the width of the blen fields
- `AxiUserWidth`, 64: user width per beat
- `MaxOutstanding`, 4: maximum in-flight reads, and separately maximum in-flight writes, per port
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-high reset
- `port_rd_req_i` / `port_rd_gnt_o`  in/out  [NumPorts]  per-port read request and grant
- `port_rd_addr_i`, `_blen_i`, `_size_i`, `_lock_i`, `_id_i`  in  [NumPorts] × shim field widths; `_id_i` is LocalIdWidth wide
- `port_rd_valid_o`, `_last_o`, `_exokay_o`  out  [NumPorts]  routed R beat
- `port_rd_rdy_i`  in  [NumPorts]  per-port R ready
- `port_rd_data_o` (64), `_user_o` (AxiUserWidth), `_id_o` (LocalIdWidth)  out  shared, broadcast to all ports
- `port_wr_req_i` / `port_wr_gnt_o`  in/out  [NumPorts]  per-port write request and grant
- `port_wr_addr_i`, `_data_i`, `_user_i`, `_be_i`, `_blen_i`, `_size_i`, `_lock_i`, `_atop_i`, `_id_i`  in  [NumPorts] × shim field widths
- `port_wr_valid_o`, `_exokay_o`  out  [NumPorts]  routed B response
- `port_wr_rdy_i`  in  [NumPorts]  per-port B ready
- `port_wr_id_o`  out  LocalIdWidth  shared B ID
- `shim_*`  out/in  mirrors the full axi_shim request/response port set, with IDs AxiIdWidth wide
- `route_err_o`  out  1  sticky flag: a response arrived carrying a port index ≥ NumPorts

## Operation
- Read and write arbitration are independent. Each has its own round-robin pointer and its own lock.
- **Eligibility.** A port is eligible when its `req_i` is high and its outstanding count for that channel is below MaxOutstanding.
- **States per channel: IDLE and LOCKED.**
  - IDLE: choose the first eligible port at or after `rr_q`, and drive its fields to the shim. Shim ID is `{port_idx, local_id}`.
  - IDLE, shim gnt in the same cycle: forward gnt to that port and set `rr_q` to selected+1 (mod NumPorts). Stay in IDLE.
  - IDLE, no gnt: register `sel_q` and go to LOCKED.
  - LOCKED: drive `sel_q` unconditionally, ignoring eligibility and other requests. On shim gnt, forward it, advance `rr_q`, and return to IDLE.
- **Write gnt timing.** Write gnt arrives when the shim completes the burst, so a write lock spans the whole burst.
- **Read counters.** `rd_cnt[p]` increments on port p's read gnt. It decrements on the handshake `shim_rd_valid & shim_rd_rdy & shim_rd_last` whose ID index equals p.
- **Write counters.** `wr_cnt[p]` increments on write gnt. It decrements on the handshake `shim_wr_valid & shim_wr_rdy` whose ID index equals p.
- **Simultaneous increment and decrement** on the same counter leaves it unchanged. Counters saturate, never wrap.
- **Response routing.**
  - The upper PortIdxWidth bits of the response ID select the port. Only that port's valid is raised.
  - `shim_rd_rdy_o` / `shim_wr_rdy_o` is taken from the selected port's rdy.
  - Index ≥ NumPorts: the response is accepted with rdy=1, no port valid is raised, and `route_err_o` is set until reset.

## Timing
- The request path is combinational from port to shim, with no added latency. Grant is combinational back to the port.
- The response path is combinational, with zero latency.
- **Reset values:**
  - all `port_*_gnt_o` = 0 and all `port_*_valid_o` = 0;
  - `shim_*_valid_o` = 0;
  - `route_err_o` = 0;
  - `rr_q` = 0, lock = IDLE, all counters = 0.
- Reset asserted mid-burst returns both channels to IDLE immediately. Recovery of the in-flight shim transaction is the system's responsibility.
- A requester dropping `req_i` while LOCKED is a protocol violation. The arbiter keeps driving `sel_q`.

## Configuration
- `AXI_SHIM_ARB_STATS_EN` defined: adds `stat_rd_stall_o` and `stat_wr_stall_o`, 32-bit outputs.
  - Each counts cycles in which at least one port requests on that channel but no shim gnt occurs.
  - The counters wrap at 2^32 and reset to 0.
- Not defined: these ports and their logic are absent.

## Structure
- Package `axi_shim_arb_pkg` holds:
  - `port_idx_t`;
  - `arb_state_e` {IDLE, LOCKED};
  - the function `tag_id(idx, local)` and its inverse `port_of(id)`.
- Sub-module `rr_arb`: a parameterised round-robin priority picker (`req`, `ptr` → one-hot `sel`, `valid`), instantiated once per channel.

## Test plan
- **Read round-robin.** Ports 0,1,2 request reads continuously with ar_ready=1. Required: grants go 0,1,2,0 on consecutive cycles, and shim IDs are 0x0,0x4,0x8 for local id 0 (NumPorts=3, AxiIdWidth=4).
- **Write lock.** Port 1 issues a 4-beat write with aw_ready delayed 3 cycles and port 0 requests mid-burst. Required: shim fields stay on port 1 until wr_gnt, then port 0 is granted the next cycle.
- **Outstanding cap.** MaxOutstanding=2 and no R responses; port 0 issues 3 reads. Required: the third read is not granted. After one R last beat with ID 0x0, the third read is granted.
- **Response routing.** An R beat with ID 0x9 arrives. Required: only `port_rd_valid_o[2]` is high with `port_rd_id_o`=1, and shim rdy follows `port_rd_rdy_i[2]`.
- **Bad index.** A B response with ID 0xC arrives. Required: no port valid, wr rdy=1, `route_err_o` goes to 1 and stays there.
- **Reset while LOCKED.** Assert `rst_i` while the write channel is LOCKED. Required: all gnt and valid outputs are 0 and the counters are 0 on the next edge.
